// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring, on magnitudes) unit.
// Writes HI/LO once per completed operation; Busy/Done/DivZero decode from the FSM state.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MultCtrl,
  input  logic             DivCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StMultRun, StDivRun, StFinish, StDz} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH:0]   work_hi_q, work_hi_d;
  logic [WIDTH-1:0] work_lo_q, work_lo_d;
  logic             booth_q, booth_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  // Booth step: hi carries one guard bit so adding/subtracting the most-negative
  // multiplicand cannot overflow.
  logic [WIDTH:0]   m_ext, booth_sum, mult_hi_nxt;
  logic [WIDTH-1:0] mult_lo_nxt;
  logic [WIDTH-1:0] b_mag, div_rem_nxt, div_quo_nxt;
  logic [WIDTH:0]   div_shift, div_diff;

  always_comb begin
    m_ext = {a_q[WIDTH-1], a_q};
    case ({work_lo_q[0], booth_q})
      2'b01:   booth_sum = work_hi_q + m_ext;
      2'b10:   booth_sum = work_hi_q - m_ext;
      default: booth_sum = work_hi_q;
    endcase
    mult_hi_nxt = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    mult_lo_nxt = {booth_sum[0], work_lo_q[WIDTH-1:1]};

    // Remainder lives in work_hi, dividend magnitude shifts out of work_lo as quotient fills in.
    b_mag     = b_q[WIDTH-1] ? -b_q : b_q;
    div_shift = {work_hi_q[WIDTH-1:0], work_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_mag};
    if (!div_diff[WIDTH]) begin
      div_rem_nxt = div_diff[WIDTH-1:0];
      div_quo_nxt = {work_lo_q[WIDTH-2:0], 1'b1};
    end else begin
      div_rem_nxt = div_shift[WIDTH-1:0];
      div_quo_nxt = {work_lo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    booth_d   = booth_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      StIdle: begin
        if (MultCtrl) begin
          a_d       = A;
          b_d       = B;
          work_hi_d = '0;
          work_lo_d = B;
          booth_d   = 1'b0;
          cnt_d     = '0;
          state_d   = StMultRun;
        end else if (DivCtrl) begin
          if (B != '0) begin
            a_d       = A;
            b_d       = B;
            work_hi_d = '0;
            work_lo_d = A[WIDTH-1] ? -A : A;
            cnt_d     = '0;
            state_d   = StDivRun;
          end else begin
            state_d = StDz;
          end
        end
      end
      StMultRun: begin
        work_hi_d = mult_hi_nxt;
        work_lo_d = mult_lo_nxt;
        booth_d   = work_lo_q[0];
        if (cnt_q == CntLast) begin
          hi_d    = mult_hi_nxt[WIDTH-1:0];
          lo_d    = mult_lo_nxt;
          state_d = StFinish;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDivRun: begin
        work_hi_d = {1'b0, div_rem_nxt};
        work_lo_d = div_quo_nxt;
        if (cnt_q == CntLast) begin
          // Truncation toward zero: quotient sign from operand signs, remainder from dividend.
          lo_d    = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -div_quo_nxt : div_quo_nxt;
          hi_d    = a_q[WIDTH-1] ? -div_rem_nxt : div_rem_nxt;
          state_d = StFinish;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFinish: state_d = StIdle;
      StDz:     state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      booth_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      booth_q   <= booth_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign HI      = hi_q;
  assign LO      = lo_q;
  assign Busy    = (state_q != StIdle);
  assign Done    = (state_q == StFinish);
  assign DivZero = (state_q == StDz);

endmodule
